aemb_ifetch_ctl: RTL and testbench
==================================

// Module: aemb_ifetch_ctl
// PURPOSE
//  Instruction-fetch sequencer between the instruction Wishbone port and the instruction buffer/decoder.
//  Owns the fetch PC and drives word requests only while prefetch space exists; this is the
//  "strobe = FIFO not full" control.
//  Queues returned words in a small prefetch FIFO and presents them in order to the decode stage.
//  Flushes and redirects on branch, discarding any in-flight word.
// PARAMETERS
//  AW      30           word-address width (byte address = {iwb_adr_o,2'b00})
//  DEPTH   4            prefetch FIFO entries; power of two, 2..16
//  RST_PC  {AW{1'b0}}   word address fetched first after reset
// PORTS
//  gclk       in   1    clock, rising edge
//  grst_n     in   1    asynchronous reset, active low
//  gena       in   1    decode stage advances this cycle (pop when ins_vld_o=1)
//  rBRA       in   1    branch taken; redirect fetch to rBRA_ADR
//  rBRA_ADR   in   AW   branch target, word address
//  iwb_stb_o  out  1    Wishbone strobe (cyc implied)
//  iwb_adr_o  out  AW   fetch word address
//  iwb_ack_i  in   1    Wishbone acknowledge
//  iwb_dat_i  in   32   fetched instruction word
//  ins_dat_o  out  32   FIFO head word; 32'h88000000 (NOP) when empty
//  ins_adr_o  out  AW   word address of ins_dat_o
//  ins_vld_o  out  1    FIFO non-empty
//  ins_hold_o out  1    =~ins_vld_o; pipeline stall request
// BEHAVIOUR
//  Reset (async, grst_n=0):
//    state=IDLE, pc=RST_PC, FIFO count=0, iwb_stb_o=0, ins_vld_o=0, ins_hold_o=1.
//    Assertion mid-transfer abandons it immediately.
//  FSM (one request outstanding max, classic Wishbone):
//    IDLE: if rBRA, pc<=rBRA_ADR and stay in IDLE.
//          Else if count+0 < DEPTH, go to FETCH and assert stb with adr=pc next cycle.
//    FETCH: stb=1, adr stable until ack.
//          On ack without rBRA: push {iwb_dat_i,pc}, pc<=pc+1.
//          Then stay in FETCH if count after push/pop < DEPTH, else go to IDLE.
//          On rBRA without ack: pc<=rBRA_ADR, go to DISCARD.
//          On rBRA with ack: drop the word, pc<=rBRA_ADR, go to IDLE.
//    DISCARD: stb stays 1 (adr unchanged) until ack; the acked word is dropped, then go to IDLE.
//          A further rBRA here only updates pc.
//  FIFO:
//    Circular buffer with read/write pointers of log2(DEPTH) bits, wrap naturally.
//    Count is log2(DEPTH)+1 bits.
//    Push and pop in the same cycle are allowed, including when full (pop frees the slot)
//    and when empty (push only; no bypass, so the word appears on ins_dat_o next cycle).
//    Pop = gena & ins_vld_o & ~rBRA.
//    rBRA clears count and pointers on the same edge; flush has priority over push and pop.
//  Latency:
//    Reset release to first stb: 1 cycle.
//    Ack to ins_vld_o: 1 cycle.
//    rBRA to first target stb: 1 cycle (IDLE) or 1 cycle after the discard ack.
//  Address arithmetic: pc+1 wraps modulo 2^AW with no fault.
//  Stb never deasserts before ack; adr never changes while stb=1.
//  iwb_dat_i is sampled only when iwb_ack_i=1 and stb=1; a stray ack with stb=0 is ignored.
// TESTING
//  1. Reset, ack every cycle, gena=1:
//     stb rises 1 cycle after reset release; adr 0,1,2,...
//     ins_vld_o rises 1 cycle after first ack; words pop in order.
//  2. gena=0, zero-wait acks:
//     exactly DEPTH=4 words accepted (adr 0..3), then stb=0, ins_hold_o=0.
//     One gena pulse pops word 0 and stb resumes at adr 4.
//  3. rBRA=1 (rBRA_ADR=0x100) while stb=1 and ack delayed 3 cycles:
//     adr holds, the acked word is dropped, FIFO empty.
//     Next stb has adr=0x100.
//  4. rBRA coincident with ack and with gena:
//     the ack word is not pushed, no pop occurs, count=0.
//     Next request is to the target.
//  5. Full FIFO with gena=1 and ack in the same cycle:
//     count stays 4, order preserved across pointer wrap.
//  6. Drop grst_n while stb=1 with ack pending:
//     stb=0 and ins_vld_o=0 immediately (asynchronous).
//     On release, fetch restarts at RST_PC.

Source files
------------

// File: rtl/aemb_ifetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : aemb_ifetch_ctl
//  Purpose  : Instruction-fetch sequencer. Owns the fetch PC, issues single
//             outstanding Wishbone word reads while prefetch space remains,
//             queues returned words in a small FIFO for the decode stage and
//             flushes/redirects on a taken branch.
//  Ports    : gclk, grst_n          clock / asynchronous active-low reset
//             gena                  decode advances (pops head when valid)
//             rBRA, rBRA_ADR        branch taken / target word address
//             iwb_stb_o, iwb_adr_o  Wishbone request (cyc implied)
//             iwb_ack_i, iwb_dat_i  Wishbone response
//             ins_dat_o, ins_adr_o  FIFO head word and its word address
//             ins_vld_o, ins_hold_o head valid / stall request
//  Revision : 1.0  initial release
// ============================================================================
module aemb_ifetch_ctl #(
   parameter int            AW     = 30,
   parameter int            DEPTH  = 4,
   parameter logic [AW-1:0] RST_PC = {AW{1'b0}}
) (
   input  logic          gclk,
   input  logic          grst_n,
   input  logic          gena,
   input  logic          rBRA,
   input  logic [AW-1:0] rBRA_ADR,
   output logic          iwb_stb_o,
   output logic [AW-1:0] iwb_adr_o,
   input  logic          iwb_ack_i,
   input  logic [31:0]   iwb_dat_i,
   output logic [31:0]   ins_dat_o,
   output logic [AW-1:0] ins_adr_o,
   output logic          ins_vld_o,
   output logic          ins_hold_o
);

   localparam int          c_PW     = $clog2(DEPTH);
   localparam logic [c_PW:0] c_DEPTH = (c_PW+1)'(DEPTH);
   localparam logic [31:0] c_NOP    = 32'h8800_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            rState, wStateNxt;
   logic [AW-1:0]     rPc, wPcNxt;
   logic [AW-1:0]     rAdr, wAdrNxt;
   logic [c_PW-1:0]   rWp, rRp;
   logic [c_PW:0]     rCnt, wCntAfter;
   logic              wPush, wPop;

   logic [31:0]       memDat [DEPTH];
   logic [AW-1:0]     memAdr [DEPTH];

   // Bus strobe is a pure decode of the registered state, so it never glitches
   // and stays high from request until the acknowledge is consumed.
   assign iwb_stb_o  = (rState != IDLE);
   assign iwb_adr_o  = rAdr;

   assign ins_vld_o  = (rCnt != '0);
   assign ins_hold_o = ~ins_vld_o;
   assign ins_dat_o  = ins_vld_o ? memDat[rRp] : c_NOP;
   assign ins_adr_o  = memAdr[rRp];

   // Only an acked FETCH without a branch delivers a word; a branch drops it.
   assign wPush     = (rState == FETCH) & iwb_ack_i & ~rBRA;
   assign wPop      = gena & ins_vld_o & ~rBRA;
   assign wCntAfter = rCnt + {{c_PW{1'b0}}, wPush} - {{c_PW{1'b0}}, wPop};

   always_comb begin
      wStateNxt = rState;
      wPcNxt    = rPc;
      case (rState)
         IDLE: begin
            if (rBRA)
               wPcNxt = rBRA_ADR;
            else if (rCnt < c_DEPTH)
               wStateNxt = FETCH;
         end
         FETCH: begin
            if (rBRA) begin
               wPcNxt    = rBRA_ADR;
               // With the ack already here nothing is left in flight.
               wStateNxt = iwb_ack_i ? IDLE : DISCARD;
            end else if (iwb_ack_i) begin
               wPcNxt    = rPc + {{(AW-1){1'b0}}, 1'b1};
               wStateNxt = (wCntAfter < c_DEPTH) ? FETCH : IDLE;
            end
         end
         DISCARD: begin
            // The stale request must complete on the bus before redirecting.
            if (rBRA)
               wPcNxt = rBRA_ADR;
            if (iwb_ack_i)
               wStateNxt = IDLE;
         end
         default: wStateNxt = IDLE;
      endcase

      // The bus address is a separate register so it stays frozen in
      // DISCARD while the PC already holds the branch target.
      wAdrNxt = rAdr;
      if (wStateNxt == FETCH)
         wAdrNxt = wPcNxt;
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         rState <= IDLE;
         rPc    <= RST_PC;
         rAdr   <= RST_PC;
      end else begin
         rState <= wStateNxt;
         rPc    <= wPcNxt;
         rAdr   <= wAdrNxt;
      end
   end

   // FIFO bookkeeping; a branch flush overrides any push or pop.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         rWp  <= '0;
         rRp  <= '0;
         rCnt <= '0;
      end else if (rBRA) begin
         rWp  <= '0;
         rRp  <= '0;
         rCnt <= '0;
      end else begin
         if (wPush)
            rWp <= rWp + 1'b1;
         if (wPop)
            rRp <= rRp + 1'b1;
         rCnt <= wCntAfter;
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge gclk) begin
      if (wPush) begin
         memDat[rWp] <= iwb_dat_i;
         memAdr[rWp] <= rPc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aemb_ifetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aemb_ifetch_ctl
//  Purpose  : Self-checking bench for aemb_ifetch_ctl. A Wishbone slave model
//             answers requests with address-derived words; stimulus pushes the
//             expected word addresses into a scoreboard queue and a monitor
//             compares every word the decode side pops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aemb_ifetch_ctl;

   logic        gclk;
   logic        grst_n;
   logic        gena;
   logic        rBRA;
   logic [29:0] rBRA_ADR;
   logic        iwb_stb_o;
   logic [29:0] iwb_adr_o;
   logic        iwb_ack_i;
   logic [31:0] iwb_dat_i;
   logic [31:0] ins_dat_o;
   logic [29:0] ins_adr_o;
   logic        ins_vld_o;
   logic        ins_hold_o;

   aemb_ifetch_ctl dut (
      .gclk      (gclk),
      .grst_n    (grst_n),
      .gena      (gena),
      .rBRA      (rBRA),
      .rBRA_ADR  (rBRA_ADR),
      .iwb_stb_o (iwb_stb_o),
      .iwb_adr_o (iwb_adr_o),
      .iwb_ack_i (iwb_ack_i),
      .iwb_dat_i (iwb_dat_i),
      .ins_dat_o (ins_dat_o),
      .ins_adr_o (ins_adr_o),
      .ins_vld_o (ins_vld_o),
      .ins_hold_o(ins_hold_o)
   );

   int          errors = 0;
   int          checks = 0;
   int          budget = 0;   // acks the slave may still give
   int          waitCyc = 0;  // wait states before each ack
   logic [29:0] sbq [$];

   initial begin
      gclk = 1'b0;
      forever #5 gclk = ~gclk;
   end

   function automatic logic [31:0] wordOf(input logic [29:0] a);
      return {2'b01, a};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge gclk);
      #1;
   endtask

   // Wishbone slave: decides the ack for the next edge shortly after each edge.
   initial begin : slave
      int waitCnt;
      waitCnt   = 0;
      iwb_ack_i = 1'b0;
      iwb_dat_i = '0;
      forever begin
         @(posedge gclk);
         #2;
         if (grst_n && iwb_stb_o && budget > 0) begin
            if (waitCnt >= waitCyc) begin
               iwb_ack_i = 1'b1;
               iwb_dat_i = wordOf(iwb_adr_o);
               budget--;
               waitCnt = 0;
            end else begin
               iwb_ack_i = 1'b0;
               waitCnt++;
            end
         end else begin
            iwb_ack_i = 1'b0;
            waitCnt   = 0;
         end
      end
   end

   // Monitor: every pop is compared against the scoreboard head.
   initial begin : monitor
      logic [29:0] e;
      forever begin
         @(negedge gclk);
         if (grst_n && gena && ins_vld_o && !rBRA) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got adr %h required none", ins_adr_o);
            end else begin
               e = sbq.pop_front();
               chk("pop_adr", {2'b00, ins_adr_o}, {2'b00, e});
               chk("pop_dat", ins_dat_o, wordOf(e));
            end
         end
      end
   end

   // Leaves the DUT just released from reset, at one unit after an edge.
   task automatic doReset();
      step();
      grst_n   = 1'b0;
      gena     = 1'b0;
      rBRA     = 1'b0;
      rBRA_ADR = '0;
      budget   = 0;
      waitCyc  = 0;
      sbq.delete();
      @(negedge gclk);
      chk("rst_stb", iwb_stb_o, 0);
      chk("rst_vld", ins_vld_o, 0);
      chk("rst_hold", ins_hold_o, 1);
      chk("rst_dat", ins_dat_o, 32'h8800_0000);
      step();
      grst_n = 1'b1;
   endtask

   initial begin : stim
      grst_n   = 1'b0;
      gena     = 1'b0;
      rBRA     = 1'b0;
      rBRA_ADR = '0;

      // ---- 1: streaming fetch with decode always advancing
      doReset();
      gena   = 1'b1;
      budget = 6;
      for (int i = 0; i < 6; i++) sbq.push_back(30'(i));
      @(negedge gclk);
      chk("t1_stb_before", iwb_stb_o, 0);
      @(negedge gclk);
      chk("t1_stb_first", iwb_stb_o, 1);
      chk("t1_adr_first", {2'b00, iwb_adr_o}, 0);
      chk("t1_vld_before", ins_vld_o, 0);
      @(negedge gclk);
      chk("t1_vld_after_ack", ins_vld_o, 1);
      repeat (12) @(negedge gclk);
      chk("t1_drained", sbq.size(), 0);
      chk("t1_vld_end", ins_vld_o, 0);
      chk("t1_adr_end", {2'b00, iwb_adr_o}, 6);

      // ---- 2: FIFO fills with decode stalled, one pop restarts fetch
      doReset();
      budget = 20;
      for (int i = 0; i < 5; i++) sbq.push_back(30'(i));
      repeat (8) @(negedge gclk);
      chk("t2_stb_full", iwb_stb_o, 0);
      chk("t2_hold_full", ins_hold_o, 0);
      chk("t2_head_adr", {2'b00, ins_adr_o}, 0);
      chk("t2_head_dat", ins_dat_o, wordOf(30'd0));
      step();
      gena = 1'b1;
      step();
      gena = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge gclk);
         if (iwb_stb_o) break;
      end
      chk("t2_stb_resume", iwb_stb_o, 1);
      chk("t2_adr_resume", {2'b00, iwb_adr_o}, 4);
      repeat (4) @(negedge gclk);
      chk("t2_stb_refull", iwb_stb_o, 0);
      chk("t2_vld_refull", ins_vld_o, 1);
      step();
      budget = 0;
      gena   = 1'b1;
      repeat (10) @(negedge gclk);
      chk("t2_drained", sbq.size(), 0);
      chk("t2_vld_end", ins_vld_o, 0);

      // ---- 3: branch while a delayed request is outstanding
      doReset();
      waitCyc = 3;
      budget  = 3;
      sbq.push_back(30'h100);
      sbq.push_back(30'h101);
      @(negedge gclk);
      @(negedge gclk);
      chk("t3_stb_req", iwb_stb_o, 1);
      step();
      rBRA     = 1'b1;
      rBRA_ADR = 30'h100;
      step();
      rBRA = 1'b0;
      @(negedge gclk);
      chk("t3_stb_hold", iwb_stb_o, 1);
      chk("t3_adr_hold", {2'b00, iwb_adr_o}, 0);
      @(negedge gclk);
      @(negedge gclk);
      chk("t3_stb_after_drop", iwb_stb_o, 0);
      chk("t3_vld_after_drop", ins_vld_o, 0);
      @(negedge gclk);
      chk("t3_stb_target", iwb_stb_o, 1);
      chk("t3_adr_target", {2'b00, iwb_adr_o}, 30'h100);
      repeat (10) @(negedge gclk);
      step();
      gena = 1'b1;
      repeat (5) @(negedge gclk);
      chk("t3_drained", sbq.size(), 0);
      chk("t3_adr_end", {2'b00, iwb_adr_o}, 30'h102);

      // ---- 4: branch coincident with ack and with decode advance
      doReset();
      budget = 3;
      repeat (3) @(negedge gclk);
      chk("t4_vld_pre", ins_vld_o, 1);
      step();
      rBRA     = 1'b1;
      rBRA_ADR = 30'h200;
      gena     = 1'b1;
      sbq.delete();
      step();
      rBRA   = 1'b0;
      budget = 1;
      sbq.push_back(30'h200);
      @(negedge gclk);
      chk("t4_vld_flushed", ins_vld_o, 0);
      chk("t4_stb_idle", iwb_stb_o, 0);
      @(negedge gclk);
      chk("t4_stb_target", iwb_stb_o, 1);
      chk("t4_adr_target", {2'b00, iwb_adr_o}, 30'h200);
      repeat (5) @(negedge gclk);
      chk("t4_drained", sbq.size(), 0);
      chk("t4_adr_end", {2'b00, iwb_adr_o}, 30'h201);

      // ---- 5: full FIFO then continuous push/pop, order across pointer wrap
      doReset();
      budget = 12;
      for (int i = 0; i < 12; i++) sbq.push_back(30'(i));
      repeat (8) @(negedge gclk);
      chk("t5_stb_full", iwb_stb_o, 0);
      step();
      gena = 1'b1;
      repeat (30) @(negedge gclk);
      chk("t5_drained", sbq.size(), 0);
      chk("t5_vld_end", ins_vld_o, 0);
      chk("t5_adr_end", {2'b00, iwb_adr_o}, 12);

      // ---- 6: asynchronous reset during an outstanding request
      doReset();
      budget = 1;
      repeat (3) @(negedge gclk);
      chk("t6_stb_pre", iwb_stb_o, 1);
      chk("t6_adr_pre", {2'b00, iwb_adr_o}, 1);
      chk("t6_vld_pre", ins_vld_o, 1);
      step();
      grst_n = 1'b0;
      #1;
      chk("t6_stb_async", iwb_stb_o, 0);
      chk("t6_vld_async", ins_vld_o, 0);
      chk("t6_hold_async", ins_hold_o, 1);
      sbq.delete();
      budget = 2;
      gena   = 1'b1;
      sbq.push_back(30'd0);
      sbq.push_back(30'd1);
      step();
      step();
      grst_n = 1'b1;
      @(negedge gclk);
      chk("t6_stb_release", iwb_stb_o, 0);
      @(negedge gclk);
      chk("t6_stb_restart", iwb_stb_o, 1);
      chk("t6_adr_restart", {2'b00, iwb_adr_o}, 0);
      repeat (8) @(negedge gclk);
      chk("t6_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
